dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024; meaning: word capacity, which maps to byte addresses 0x0000_0000..0x0000_0FFF.
REQ-002 SHALL have parameter LATENCY, default 2, legal range 1..15; meaning: cycles from the request-accept edge to the first cycle with resp_valid high.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  the CPU presents a request.
REQ-006 SHALL have port req_ready  output  1  the responder accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_be  input  4  byte enables for stores, with bit i selecting byte lane i.
REQ-010 SHALL have port req_wdata  input  32  store data.
REQ-011 SHALL have port req_pc  input  32  PC of the issuing instruction, used only for the write log.
REQ-012 SHALL have port resp_valid  output  1  a response is present.
REQ-013 SHALL have port resp_ready  input  1  the CPU consumes the response.
REQ-014 SHALL have port resp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err  output  1  the request was misaligned or out of range.

Function
REQ-016 SHALL implement the states CLEAR, IDLE, WAIT and RESP.
REQ-017 In CLEAR it SHALL write 0 to mem[clr_idx] and increment clr_idx each cycle, with req_ready=0; after writing index DEPTH_WORDS-1 it SHALL go to IDLE.
REQ-018 In IDLE it SHALL drive req_ready=1; a handshake is req_valid&&req_ready at a rising edge, which captures we, addr, be, wdata and pc.
REQ-019 On a handshake with LATENCY=1 it SHALL go to RESP; otherwise it SHALL go to WAIT with cnt=LATENCY-1.
REQ-020 In WAIT it SHALL decrement cnt each cycle and go to RESP when cnt==1; req_ready SHALL be 0 in WAIT and RESP.
REQ-021 It SHALL perform the memory access exactly once, on the edge that enters RESP.
REQ-022 It SHALL flag an error when addr[1:0]!=0 or addr[31:12]!=0; an errored request SHALL set resp_err=1, resp_rdata=0 and leave memory unwritten.
REQ-023 A load SHALL set resp_rdata to mem[addr[11:2]].
REQ-024 A store SHALL update only the byte lanes enabled by req_be and SHALL set resp_rdata=0.
REQ-025 A store with be=0 SHALL be a legal no-op that still produces a response.
REQ-026 In RESP it SHALL hold resp_valid=1 with stable data until resp_ready=1, then go to IDLE at that edge.
REQ-027 A new request SHALL be accepted no earlier than the cycle after the response handshake, so at most one request is outstanding.
REQ-028 Every committed store SHALL emit the simulation log line "@<pc hex8>: *<addr hex8> <= <merged word hex8>", where the merged word is the full post-write word.
REQ-029 In IDLE, resp_valid, resp_err and resp_rdata SHALL be 0.
REQ-030 req_valid asserted during CLEAR SHALL be ignored, not queued.

Reset
REQ-031 On reset high at a rising edge it SHALL set state=CLEAR, clr_idx=0, cnt=0, req_ready=0, resp_valid=0, resp_err=0 and resp_rdata=0, and all captured request registers to 0.
REQ-032 Reset in any state, including mid-WAIT or RESP, SHALL drop the pending request with no memory write and no response, and SHALL restart the clear sweep.
REQ-033 Memory SHALL be fully zero before the first req_ready=1, which occurs DEPTH_WORDS cycles after reset deasserts.

Structure
REQ-034 A shared package SHALL hold the state enum (CLEAR, IDLE, WAIT, RESP), ADDR_HI_LIMIT=12 and the default DEPTH_WORDS and LATENCY values.
REQ-035 The storage array SHALL be a sub-module, dmem_ram (one synchronous write port with 4-bit byte enables, one asynchronous read port); the FSM, counter and logging SHALL stay in dmem_responder.

Verification
REQ-036 Clear sweep: hold reset 2 cycles, then release -> req_ready=0 for exactly 1024 cycles then 1, and a load of 0x0000_0FFC returns 0x0000_0000.
REQ-037 Store then load with LATENCY=2: store addr 0x10, be=0xF, wdata 0xDEADBEEF accepted at edge T -> resp_valid at T+2, log line printed; a following load of 0x10 returns 0xDEADBEEF with err=0.
REQ-038 Byte enables: store 0x11223344 be=0x5 over 0xDEADBEEF at 0x10 -> a load returns 0xDE22BE44.
REQ-039 Errors: loads of 0x12 and 0x1000 -> resp_err=1, resp_rdata=0; a store to 0x1000 leaves mem[0] unchanged and prints no log line.
REQ-040 Backpressure: resp_ready held low 5 cycles -> resp_valid and data stable for 5 cycles, req_ready=0 throughout, IDLE the cycle after resp_ready=1.
REQ-041 Reset mid-WAIT: a store to 0x20 is accepted, then reset is pulsed 1 cycle later -> no response, no log line, and mem[8]=0 after the clear sweep.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam int ADDR_HI_LIMIT       = 12;
  localparam int IDX_W               = ADDR_HI_LIMIT - 2;
  localparam int DEFAULT_DEPTH_WORDS = 1024;
  localparam int DEFAULT_LATENCY     = 2;

  // Misaligned, above the 4 KiB window, or beyond the populated words.
  function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] depth);
    return (addr[1:0] != 2'b00) ||
           (addr[31:ADDR_HI_LIMIT] != '0) ||
           (32'(addr[ADDR_HI_LIMIT-1:2]) >= depth);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-wide storage: one synchronous byte-enabled write port, one asynchronous read port.
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IW          = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [3:0]    wbe,
  input  logic [31:0]   wdata,
  input  logic [IW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wbe[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: clears memory after reset, then serves
// loads/stores with a fixed response latency and logs every committed store.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);
  localparam logic [3:0]       LAT_M1   = 4'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               cap_we_q, cap_we_d;
  logic [31:0]        cap_addr_q, cap_addr_d;
  logic [3:0]         cap_be_q, cap_be_d;
  logic [31:0]        cap_wdata_q, cap_wdata_d;
  logic [31:0]        cap_pc_q, cap_pc_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;

  logic               hs;
  logic               acc_we;
  logic [31:0]        acc_addr;
  logic [3:0]         acc_be;
  logic [31:0]        acc_wdata;
  logic [31:0]        acc_pc;
  logic               acc_err;
  logic               enter_resp;
  logic               commit_store;
  logic               ram_we;
  logic [IDX_W-1:0]   ram_waddr;
  logic [3:0]         ram_wbe;
  logic [31:0]        ram_wdata;
  logic [31:0]        ram_rdata;
  logic [31:0]        merged_word;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  assign hs = req_valid && req_ready;

  // With LATENCY=1 the access happens on the accept edge, so it must use the live request.
  assign acc_we    = (state_q == IDLE) ? req_we    : cap_we_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr  : cap_addr_q;
  assign acc_be    = (state_q == IDLE) ? req_be    : cap_be_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : cap_wdata_q;
  assign acc_pc    = (state_q == IDLE) ? req_pc    : cap_pc_q;
  assign acc_err   = addr_err(acc_addr, 32'(DEPTH_WORDS));

  assign enter_resp   = ((state_q == IDLE) && hs && (LATENCY == 1)) ||
                        ((state_q == WAIT) && (cnt_q == 4'd1));
  assign commit_store = enter_resp && acc_we && !acc_err && !reset;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_word[8*gi +: 8] = acc_be[gi] ? acc_wdata[8*gi +: 8] : ram_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    ram_we    = commit_store;
    ram_waddr = acc_addr[ADDR_HI_LIMIT-1:2];
    ram_wbe   = acc_be;
    ram_wdata = acc_wdata;
    if (state_q == CLEAR) begin
      ram_we    = !reset;
      ram_waddr = clr_idx_q;
      ram_wbe   = 4'hF;
      ram_wdata = '0;
    end
  end

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IW          (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wbe   (ram_wbe),
    .wdata (ram_wdata),
    .raddr (acc_addr[ADDR_HI_LIMIT-1:2]),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    cnt_d        = cnt_q;
    cap_we_d     = cap_we_q;
    cap_addr_d   = cap_addr_q;
    cap_be_d     = cap_be_q;
    cap_wdata_d  = cap_wdata_q;
    cap_pc_d     = cap_pc_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;

    unique case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d   = IDLE;
          clr_idx_d = '0;
        end
      end
      IDLE: begin
        if (hs) begin
          cap_we_d    = req_we;
          cap_addr_d  = req_addr;
          cap_be_d    = req_be;
          cap_wdata_d = req_wdata;
          cap_pc_d    = req_pc;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
        end
      end
    endcase

    if (enter_resp) begin
      resp_valid_d = 1'b1;
      resp_err_d   = acc_err;
      resp_rdata_d = (!acc_we && !acc_err) ? ram_rdata : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CLEAR;
      clr_idx_q    <= '0;
      cnt_q        <= '0;
      cap_we_q     <= 1'b0;
      cap_addr_q   <= '0;
      cap_be_q     <= '0;
      cap_wdata_q  <= '0;
      cap_pc_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      cnt_q        <= cnt_d;
      cap_we_q     <= cap_we_d;
      cap_addr_q   <= cap_addr_d;
      cap_be_q     <= cap_be_d;
      cap_wdata_q  <= cap_wdata_d;
      cap_pc_q     <= cap_pc_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (commit_store) begin
      $display("@%08h: *%08h <= %08h", acc_pc, acc_addr, merged_word);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Table-driven bench with a response scoreboard plus hand-written reset/backpressure sequences.
module tb_dmem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_be     (req_be),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] status();
    return {29'b0, resp_valid, req_ready, resp_err, resp_rdata};
  endfunction

  task automatic add_vec(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [31:0] rd, input logic err);
    vec_t v;
    v.we = we; v.addr = addr; v.be = be; v.wdata = wdata;
    v.pc = 32'h0000_1000 + 32'(vecs.size() * 4);
    v.exp_rdata = rd; v.exp_err = err;
    vecs.push_back(v);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 3000) begin
      tick();
      n++;
    end
    if (!req_ready) chk("ready_timeout", {63'b0, req_ready}, 64'd1);
  endtask

  // Issue one request, check latency and scoreboard data, optionally hold off resp_ready.
  task automatic issue(input vec_t v, input int hold);
    int   cyc;
    exp_t e;
    logic [32:0] snap;
    wait_ready();
    req_we = v.we; req_addr = v.addr; req_be = v.be; req_wdata = v.wdata; req_pc = v.pc;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    sb.push_back('{v.exp_rdata, v.exp_err});
    cyc = 1;
    while (!resp_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(LAT));
    e = sb.pop_front();
    if (!resp_valid) return;
    chk("rdata", {32'b0, resp_rdata}, {32'b0, e.rdata});
    chk("err", {63'b0, resp_err}, {63'b0, e.err});
    $display("txn we=%0d addr=%08h be=%h wdata=%08h -> rdata=%08h err=%0d lat=%0d",
             v.we, v.addr, v.be, v.wdata, resp_rdata, resp_err, cyc);
    snap = {resp_err, resp_rdata};
    for (int k = 0; k < hold; k++) begin
      chk("bp_hold", status(), {29'b0, 1'b1, 1'b0, snap});
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("idle_after", status(), {29'b0, 1'b0, 1'b1, 1'b0, 32'b0});
  endtask

  // Called #1 after the edge that releases reset; optionally pokes req_valid during the sweep.
  task automatic sweep(input int poke);
    int n = 0;
    bit seen = 1'b0;
    if (poke > 0) begin
      req_we = 1'b1; req_addr = 32'h24; req_be = 4'hF; req_wdata = 32'h7777_7777;
      req_valid = 1'b1;
    end
    while (!req_ready && n < 3000) begin
      if (resp_valid) seen = 1'b1;
      if (n == poke) req_valid = 1'b0;
      tick();
      n++;
    end
    req_valid = 1'b0;
    chk("clear_len", 64'(n), 64'(DEPTH));
    chk("clear_no_resp", {63'b0, seen}, 64'd0);
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0; req_pc = '0;

    add_vec(1'b0, 32'h0000_0FFC, 4'h0, 32'h0,          32'h0000_0000, 1'b0);
    add_vec(1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF,  32'h0000_0000, 1'b0);
    add_vec(1'b0, 32'h0000_0010, 4'h0, 32'h0,          32'hDEAD_BEEF, 1'b0);
    add_vec(1'b1, 32'h0000_0010, 4'h5, 32'h1122_3344,  32'h0000_0000, 1'b0);
    add_vec(1'b0, 32'h0000_0010, 4'h0, 32'h0,          32'hDE22_BE44, 1'b0);
    add_vec(1'b0, 32'h0000_0012, 4'h0, 32'h0,          32'h0000_0000, 1'b1);
    add_vec(1'b0, 32'h0000_1000, 4'h0, 32'h0,          32'h0000_0000, 1'b1);
    add_vec(1'b1, 32'h0000_1000, 4'hF, 32'hCAFE_F00D,  32'h0000_0000, 1'b1);
    add_vec(1'b0, 32'h0000_0000, 4'h0, 32'h0,          32'h0000_0000, 1'b0);
    add_vec(1'b1, 32'h0000_0014, 4'h0, 32'hFFFF_FFFF,  32'h0000_0000, 1'b0);
    add_vec(1'b0, 32'h0000_0014, 4'h0, 32'h0,          32'h0000_0000, 1'b0);
    add_vec(1'b1, 32'h0000_0018, 4'hA, 32'hAABB_CCDD,  32'h0000_0000, 1'b0);
    add_vec(1'b0, 32'h0000_0018, 4'h0, 32'h0,          32'hAA00_CC00, 1'b0);
    add_vec(1'b1, 32'h0000_0000, 4'h8, 32'h1234_5678,  32'h0000_0000, 1'b0);
    add_vec(1'b0, 32'h0000_0000, 4'h0, 32'h0,          32'h1200_0000, 1'b0);
    add_vec(1'b1, 32'h8000_0000, 4'hF, 32'h0BAD_0BAD,  32'h0000_0000, 1'b1);
    add_vec(1'b1, 32'h0000_0003, 4'hF, 32'h0BAD_0BAD,  32'h0000_0000, 1'b1);
    add_vec(1'b0, 32'h0000_0000, 4'h0, 32'h0,          32'h1200_0000, 1'b0);

    tick();
    chk("reset_state", status(), 64'd0);
    tick();
    reset = 1'b0;
    sweep(0);

    foreach (vecs[i]) issue(vecs[i], 0);

    v = '{1'b0, 32'h10, 4'h0, 32'h0, 32'h2000, 32'hDE22_BE44, 1'b0};
    issue(v, 5);

    // Reset lands on the edge that would have entered RESP: the store must vanish.
    wait_ready();
    req_we = 1'b1; req_addr = 32'h20; req_be = 4'hF; req_wdata = 32'h55AA_55AA; req_pc = 32'h3000;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_no_resp", status(), 64'd0);
    sweep(10);

    v = '{1'b0, 32'h20, 4'h0, 32'h0, 32'h3004, 32'h0, 1'b0};
    issue(v, 0);
    v = '{1'b0, 32'h24, 4'h0, 32'h0, 32'h3008, 32'h0, 1'b0};
    issue(v, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
